// File: rtl/seg_timer_pkg.sv
// Shared types and constants for the N-digit BCD timer and its 7-segment digit drivers.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied in seg7_digit.
package seg_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  localparam int DP_BIT = 7;

endpackage

// File: rtl/seg7_digit.sv
// One BCD digit to a {dp,g,f,e,d,c,b,a} segment byte, with blanking and selectable polarity.
module seg7_digit
  import seg_timer_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] raw;

  always_comb begin
    raw = 8'h00;
    if (!blank) begin
      case (bcd)
        4'd0:    raw[6:0] = GLYPH_0;
        4'd1:    raw[6:0] = GLYPH_1;
        4'd2:    raw[6:0] = GLYPH_2;
        4'd3:    raw[6:0] = GLYPH_3;
        4'd4:    raw[6:0] = GLYPH_4;
        4'd5:    raw[6:0] = GLYPH_5;
        4'd6:    raw[6:0] = GLYPH_6;
        4'd7:    raw[6:0] = GLYPH_7;
        4'd8:    raw[6:0] = GLYPH_8;
        4'd9:    raw[6:0] = GLYPH_9;
        default: raw[6:0] = GLYPH_BLANK;
      endcase
    end
    raw[DP_BIT] = dp;
    seg = (ACTIVE_LOW != 0) ? ~raw : raw;
  end

endmodule

// File: rtl/seg_timer_nd.sv
// N-digit BCD up/down timer with start/pause/resume from a raw push-button and 7-segment drive.
// The button is synchronised and edge-detected; one press is one event regardless of hold time.
module seg_timer_nd
  import seg_timer_pkg::*;
#(
  parameter int DIGITS         = 2,
  parameter int CHAVE_W        = 4,
  parameter int TICK_DIV       = 50000000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 0
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  start_export,
  input  logic [CHAVE_W-1:0]    chave_export,
  input  logic                  mode_export,
  output logic [8*DIGITS-1:0]   seg_export,
  output logic                  busy_export,
  output logic                  done_export
);

  localparam int                  BCD_W   = 4 * DIGITS;
  localparam int                  PS_W    = $clog2(TICK_DIV);
  localparam logic [63:0]         MAX_VAL = 64'(10 ** DIGITS - 1);
  localparam logic [8*DIGITS-1:0] SEG_OFF = {(8*DIGITS){SEG_ACTIVE_LOW != 0}};

  // Double-dabble conversion; values beyond the display range saturate to all nines.
  function automatic logic [BCD_W-1:0] to_bcd(input logic [CHAVE_W-1:0] bin);
    logic [BCD_W-1:0] bcd;
    bcd = '0;
    if (64'(bin) > MAX_VAL) begin
      for (int d = 0; d < DIGITS; d++) bcd[4*d +: 4] = 4'd9;
      return bcd;
    end
    for (int i = CHAVE_W - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++)
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      bcd = {bcd[BCD_W-2:0], bin[i]};
    end
    return bcd;
  endfunction

  // Decimal increment/decrement with carry/borrow rippling across digits.
  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] v, input logic up);
    logic [BCD_W-1:0] r;
    logic             c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (up) begin
          if (r[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
          else begin r[4*d +: 4] = r[4*d +: 4] + 4'd1; c = 1'b0; end
        end else begin
          if (r[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'd9;
          else begin r[4*d +: 4] = r[4*d +: 4] - 4'd1; c = 1'b0; end
        end
      end
    end
    return r;
  endfunction

  state_t             state, state_nx;
  logic               sync_p0, sync_p1, sync_p2, evt;
  logic [PS_W-1:0]    presc;
  logic [BCD_W-1:0]   count, target, preset_bcd, stepped, term, disp;
  logic               mode_q, tick, hit, lz;
  logic               busy_nx, done_nx;
  logic [DIGITS-1:0]  dp_nx, blank_nx;
  logic [8*DIGITS-1:0] seg_nx;

  // Stage p0..p1: metastability filter; p2 + evt: rising-edge event, registered.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      evt     <= 1'b0;
    end else begin
      sync_p0 <= start_export;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      evt     <= sync_p1 & ~sync_p2;
    end
  end

  always_comb begin
    preset_bcd = to_bcd(chave_export);
    tick       = (state == RUN) && (presc == PS_W'(TICK_DIV - 1));
    stepped    = bcd_step(count, mode_q);
    term       = mode_q ? target : '0;
    hit        = tick && (stepped == term);
    disp       = (state == IDLE) ? (mode_export ? '0 : preset_bcd) : count;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (evt) state_nx = (preset_bcd == '0) ? DONE : RUN;
      RUN:     if (hit) state_nx = DONE;
               else if (evt) state_nx = PAUSE;
      PAUSE:   if (evt) state_nx = RUN;
      DONE:    if (evt) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      presc  <= '0;
      count  <= '0;
      target <= '0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (evt) begin
          count  <= mode_export ? '0 : preset_bcd;
          target <= preset_bcd;
          mode_q <= mode_export;
          presc  <= '0;
        end
        RUN: if (tick) begin
          presc <= '0;
          count <= stepped;
        end else begin
          presc <= presc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_nx  = (state == RUN) || (state == PAUSE);
    done_nx  = (state == DONE);
    dp_nx    = '0;
    if (state == DONE)       dp_nx    = '1;
    else if (state == PAUSE) dp_nx[0] = 1'b1;
    blank_nx = '0;
    lz       = 1'b1;
    for (int d = DIGITS - 1; d > 0; d--) begin
      lz          = lz && (disp[4*d +: 4] == 4'd0);
      blank_nx[d] = (BLANK_LZ != 0) && lz;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_digit #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_digit (
      .bcd   (disp[4*g +: 4]),
      .blank (blank_nx[g]),
      .dp    (dp_nx[g]),
      .seg   (seg_nx[8*g +: 8])
    );
  end

  // Output stage: one register after count/state decode.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      seg_export  <= SEG_OFF;
      busy_export <= 1'b0;
      done_export <= 1'b0;
    end else begin
      seg_export  <= seg_nx;
      busy_export <= busy_nx;
      done_export <= done_nx;
    end
  end

endmodule

// File: tb/tb_seg_timer_nd.sv
// Directed bench for seg_timer_nd: 2-digit active-low instance plus a 1-digit instance
// used to observe preset saturation.
module tb_seg_timer_nd;

  logic        clk = 1'b0;
  logic        rst, start, mode;
  logic [3:0]  chave;
  logic [15:0] seg;
  logic        busy, done;
  logic [7:0]  seg1;
  logic        busy1, done1;
  logic        seen_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_timer_nd #(.DIGITS(2), .CHAVE_W(4), .TICK_DIV(4), .SEG_ACTIVE_LOW(1), .BLANK_LZ(0)) u_dut (
    .clk_clk(clk), .reset_reset(rst), .start_export(start), .chave_export(chave),
    .mode_export(mode), .seg_export(seg), .busy_export(busy), .done_export(done)
  );

  seg_timer_nd #(.DIGITS(1), .CHAVE_W(4), .TICK_DIV(4), .SEG_ACTIVE_LOW(1), .BLANK_LZ(0)) u_dut1 (
    .clk_clk(clk), .reset_reset(rst), .start_export(start), .chave_export(chave),
    .mode_export(mode), .seg_export(seg1), .busy_export(busy1), .done_export(done1)
  );

  // Active-low glyph table, dp off; lighting dp clears bit 7.
  function automatic logic [7:0] dig(input int v, input bit dp);
    logic [7:0] t [10];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return dp ? (t[v] & 8'h7F) : t[v];
  endfunction

  function automatic logic [15:0] seg2(input int tens, input int units, input bit dpt, input bit dpu);
    return {dig(tens, dpt), dig(units, dpu)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; chave = 4'd0; mode = 1'b0;
    wait_cyc(3);
    chk("reset_seg", 32'(seg), 32'hFFFF);
    chk("reset_seg1", 32'(seg1), 32'hFF);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Idle display follows the preset.
    chave = 4'd12;
    wait_cyc(5);
    chk("idle_12", 32'(seg), 32'hF9A4);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("sat_1digit_12", 32'(seg1), 32'h90);

    // Down count 3..0 with start held for many cycles.
    chave = 4'd3;
    wait_cyc(2);
    chk("idle_3", 32'(seg), 32'(seg2(0, 3, 0, 0)));
    start = 1'b1;
    wait_cyc(5);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_seg3", 32'(seg), 32'(seg2(0, 3, 0, 0)));
    wait_cyc(4);
    chk("down_2", 32'(seg), 32'(seg2(0, 2, 0, 0)));
    wait_cyc(4);
    chk("down_1", 32'(seg), 32'(seg2(0, 1, 0, 0)));
    wait_cyc(4);
    chk("done_seg", 32'(seg), 32'(seg2(0, 0, 1, 1)));
    chk("done_flag", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    start = 1'b0;
    wait_cyc(6);
    chk("held_single_event", 32'(done), 32'd1);

    press();
    wait_cyc(4);
    chk("back_idle_done", 32'(done), 32'd0);
    chk("back_idle_seg", 32'(seg), 32'(seg2(0, 3, 0, 0)));

    // Pause at count 2, hold, resume from the frozen prescaler.
    press();
    wait_cyc(5);
    press();
    wait_cyc(4);
    chk("pause_seg", 32'(seg), 32'(seg2(0, 2, 0, 1)));
    chk("pause_busy", 32'(busy), 32'd1);
    wait_cyc(20);
    chk("pause_hold", 32'(seg), 32'(seg2(0, 2, 0, 1)));
    press();
    wait_cyc(5);
    chk("resume_seg2", 32'(seg), 32'(seg2(0, 2, 0, 0)));
    wait_cyc(1);
    chk("resume_partial_step", 32'(seg), 32'(seg2(0, 1, 0, 0)));
    wait_cyc(4);
    chk("resume_done", 32'(done), 32'd1);
    chk("resume_done_seg", 32'(seg), 32'(seg2(0, 0, 1, 1)));
    press();
    wait_cyc(4);

    // Zero preset goes straight to DONE.
    chave = 4'd0;
    wait_cyc(2);
    press();
    seen_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_cyc(1);
      seen_busy |= busy;
    end
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_never_busy", 32'(seen_busy), 32'd0);
    chk("zero_seg", 32'(seg), 32'(seg2(0, 0, 1, 1)));
    press();
    wait_cyc(4);
    chk("zero_back_idle", 32'(done), 32'd0);

    chave = 4'd15;
    wait_cyc(2);
    chk("idle_15", 32'(seg), 32'(seg2(1, 5, 0, 0)));
    chk("sat_1digit_15", 32'(seg1), 32'h90);

    // Up count 00..11 with decimal carry.
    mode = 1'b1; chave = 4'd11;
    wait_cyc(2);
    chk("up_idle", 32'(seg), 32'(seg2(0, 0, 0, 0)));
    press();
    wait_cyc(8);
    chk("up_01", 32'(seg), 32'(seg2(0, 1, 0, 0)));
    wait_cyc(32);
    chk("up_09", 32'(seg), 32'(seg2(0, 9, 0, 0)));
    wait_cyc(4);
    chk("up_carry_10", 32'(seg), 32'(seg2(1, 0, 0, 0)));
    chk("up_not_done", 32'(done), 32'd0);
    wait_cyc(4);
    chk("up_done_seg", 32'(seg), 32'(seg2(1, 1, 1, 1)));
    chk("up_done", 32'(done), 32'd1);
    press();
    wait_cyc(4);
    chk("up_back_idle", 32'(seg), 32'(seg2(0, 0, 0, 0)));
    chk("up_back_done", 32'(done), 32'd0);

    // Reset during RUN at count 5.
    mode = 1'b0; chave = 4'd9;
    wait_cyc(2);
    press();
    wait_cyc(20);
    chk("pre_reset_5", 32'(seg), 32'(seg2(0, 5, 0, 0)));
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    wait_cyc(1);
    chk("mid_reset_seg", 32'(seg), 32'hFFFF);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    wait_cyc(2);
    chk("post_reset_idle", 32'(seg), 32'(seg2(0, 9, 0, 0)));
    wait_cyc(6);
    chk("post_reset_no_done", 32'(done), 32'd0);
    chk("post_reset_no_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
